// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron core.
//
// Integrates a signed per-cycle dendrite current into a saturating signed membrane
// potential. A periodic leak tick subtracts membrane >>> LEAK_SHIFT. When the potential
// reaches v_thresh the core emits a one-cycle spike, reloads v_reset and, if
// tau_ref_scale is non-zero, spends exactly tau_ref_scale cycles in a refractory state.
// Leak period, refractory period, threshold and reset potential are programmed through
// a serial shadow register that daisy-chains across neurons. cfg_load copies the
// shadow register into the active configuration.
//
// Ports:
//   clk               sole clock
//   reset             asynchronous, active-high
//   input_spike_valid dendrite_current is valid this cycle
//   dendrite_current  signed current, sign-extended before use
//   cfg_shift         shift the config chain by one bit
//   cfg_din           serial config input
//   cfg_dout          serial config output (MSB of the shadow register)
//   cfg_load          copy the shadow register into the active config
//   output_spike      one-cycle spike pulse
//   refractory        high while in the refractory state
//   membrane          current signed membrane potential
//   spike_count       saturating spike count, cleared only by reset
module lif_neuron_core #(
  parameter int unsigned CURRENT_WIDTH  = 12,
  parameter int unsigned COUNTER_WIDTH  = 8,
  parameter int unsigned MEMBRANE_WIDTH = 16,
  parameter int unsigned LEAK_SHIFT     = 4,
  parameter int unsigned DEF_TAU_MEM    = 16,
  parameter int unsigned DEF_TAU_REF    = 16,
  parameter logic [MEMBRANE_WIDTH-1:0] DEF_V_THRESH = 16'h1000,
  parameter logic [MEMBRANE_WIDTH-1:0] DEF_V_RESET  = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      input_spike_valid,
  input  logic [CURRENT_WIDTH-1:0]  dendrite_current,
  input  logic                      cfg_shift,
  input  logic                      cfg_din,
  output logic                      cfg_dout,
  input  logic                      cfg_load,
  output logic                      output_spike,
  output logic                      refractory,
  output logic [MEMBRANE_WIDTH-1:0] membrane,
  output logic [COUNTER_WIDTH-1:0]  spike_count
);

  localparam int unsigned CFG_W = 2 * COUNTER_WIDTH + 2 * MEMBRANE_WIDTH;
  // Two guard bits: membrane - leak + current can never leave this range.
  localparam int unsigned EXT_W = MEMBRANE_WIDTH + 2;

  localparam logic [CFG_W-1:0] CFG_DEF = {COUNTER_WIDTH'(DEF_TAU_MEM),
                                          COUNTER_WIDTH'(DEF_TAU_REF),
                                          DEF_V_THRESH, DEF_V_RESET};

  localparam logic signed [EXT_W-1:0] V_MAX_EXT = {3'b000, {(MEMBRANE_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] V_MIN_EXT = {3'b111, {(MEMBRANE_WIDTH-1){1'b0}}};
  localparam logic signed [MEMBRANE_WIDTH-1:0] V_MAX = {1'b0, {(MEMBRANE_WIDTH-1){1'b1}}};
  localparam logic signed [MEMBRANE_WIDTH-1:0] V_MIN = {1'b1, {(MEMBRANE_WIDTH-1){1'b0}}};

  typedef enum logic {StIntegrate, StRefract} state_e;

  state_e                             state_q, state_d;
  logic [CFG_W-1:0]                   shadow_q, shadow_d;
  logic [CFG_W-1:0]                   active_q, active_d;
  logic [COUNTER_WIDTH-1:0]           leak_cnt_q, leak_cnt_d;
  logic [COUNTER_WIDTH-1:0]           ref_cnt_q, ref_cnt_d;
  logic signed [MEMBRANE_WIDTH-1:0]   membrane_q, membrane_d;
  logic                               spike_q, spike_d;
  logic                               refractory_q, refractory_d;
  logic [COUNTER_WIDTH-1:0]           spike_count_q, spike_count_d;

  // Active configuration fields.
  logic [COUNTER_WIDTH-1:0]         tau_mem;
  logic [COUNTER_WIDTH-1:0]         tau_ref;
  logic signed [MEMBRANE_WIDTH-1:0] v_thresh;
  logic signed [MEMBRANE_WIDTH-1:0] v_reset;

  assign {tau_mem, tau_ref, v_thresh, v_reset} = active_q;

  // Integration datapath.
  logic                             leak_tick;
  logic signed [MEMBRANE_WIDTH-1:0] leak;
  logic signed [EXT_W-1:0]          mem_ext;
  logic signed [EXT_W-1:0]          leak_ext;
  logic signed [EXT_W-1:0]          inc_ext;
  logic signed [EXT_W-1:0]          sum_ext;
  logic signed [MEMBRANE_WIDTH-1:0] v_next;

  assign leak_tick = (leak_cnt_q == tau_mem);

  always_comb begin
    leak     = leak_tick ? (membrane_q >>> LEAK_SHIFT) : '0;
    mem_ext  = {{2{membrane_q[MEMBRANE_WIDTH-1]}}, membrane_q};
    leak_ext = {{2{leak[MEMBRANE_WIDTH-1]}}, leak};
    inc_ext  = '0;
    if (input_spike_valid) begin
      inc_ext = {{(EXT_W-CURRENT_WIDTH){dendrite_current[CURRENT_WIDTH-1]}}, dendrite_current};
    end
    sum_ext = mem_ext - leak_ext + inc_ext;
    if (sum_ext > V_MAX_EXT) begin
      v_next = V_MAX;
    end else if (sum_ext < V_MIN_EXT) begin
      v_next = V_MIN;
    end else begin
      v_next = sum_ext[MEMBRANE_WIDTH-1:0];
    end
  end

  // Config chain. A load in the same cycle as a shift takes the pre-shift shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_shift) begin
      shadow_d = {shadow_q[CFG_W-2:0], cfg_din};
    end
    if (cfg_load) begin
      active_d = shadow_q;
    end
  end

  // Leak counter runs in every state; restarted by a config load so the new period
  // starts from a known phase.
  always_comb begin
    leak_cnt_d = leak_cnt_q + 1'b1;
    if (cfg_load || leak_tick) begin
      leak_cnt_d = '0;
    end
  end

  // Neuron FSM.
  always_comb begin
    state_d       = state_q;
    membrane_d    = membrane_q;
    spike_d       = 1'b0;
    ref_cnt_d     = ref_cnt_q;
    spike_count_d = spike_count_q;
    unique case (state_q)
      StIntegrate: begin
        if (v_next >= v_thresh) begin
          membrane_d = v_reset;
          spike_d    = 1'b1;
          ref_cnt_d  = tau_ref;
          if (spike_count_q != '1) begin
            spike_count_d = spike_count_q + 1'b1;
          end
          if (tau_ref != '0) begin
            state_d = StRefract;
          end
        end else begin
          membrane_d = v_next;
        end
      end
      StRefract: begin
        // Membrane is held; inputs and leak are ignored.
        ref_cnt_d = ref_cnt_q - 1'b1;
        if (ref_cnt_q == COUNTER_WIDTH'(1)) begin
          state_d = StIntegrate;
        end
      end
    endcase
    refractory_d = (state_d == StRefract);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIntegrate;
      shadow_q      <= CFG_DEF;
      active_q      <= CFG_DEF;
      leak_cnt_q    <= '0;
      ref_cnt_q     <= '0;
      membrane_q    <= DEF_V_RESET;
      spike_q       <= 1'b0;
      refractory_q  <= 1'b0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      leak_cnt_q    <= leak_cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      membrane_q    <= membrane_d;
      spike_q       <= spike_d;
      refractory_q  <= refractory_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign cfg_dout     = shadow_q[CFG_W-1];
  assign output_spike = spike_q;
  assign refractory   = refractory_q;
  assign membrane     = membrane_q;
  assign spike_count  = spike_count_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed self-checking bench for lif_neuron_core with default parameters.
module tb_lif_neuron_core;

  localparam logic [47:0] CFG_DEF = {8'd16, 8'd16, 16'h1000, 16'h0000};

  logic        clk;
  logic        reset;
  logic        input_spike_valid;
  logic [11:0] dendrite_current;
  logic        cfg_shift;
  logic        cfg_din;
  logic        cfg_dout;
  logic        cfg_load;
  logic        output_spike;
  logic        refractory;
  logic [15:0] membrane;
  logic [7:0]  spike_count;

  int n_vec = 0;
  int n_err = 0;

  lif_neuron_core dut (
    .clk               (clk),
    .reset             (reset),
    .input_spike_valid (input_spike_valid),
    .dendrite_current  (dendrite_current),
    .cfg_shift         (cfg_shift),
    .cfg_din           (cfg_din),
    .cfg_dout          (cfg_dout),
    .cfg_load          (cfg_load),
    .output_spike      (output_spike),
    .refractory        (refractory),
    .membrane          (membrane),
    .spike_count       (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Shift a word in MSB first, checking that cfg_dout replays the prior shadow contents.
  task automatic cfg_write(input logic [47:0] w, input logic [47:0] prior);
    for (int k = 0; k < 48; k++) begin
      check("cfg_dout", 64'(cfg_dout), 64'(prior[47-k]));
      cfg_shift = 1'b1;
      cfg_din   = w[47-k];
      step();
    end
    cfg_shift = 1'b0;
    cfg_din   = 1'b0;
  endtask

  task automatic cfg_commit();
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [11:0] cur);
    input_spike_valid = v;
    dendrite_current  = cur;
  endtask

  initial begin
    reset = 1'b1;
    input_spike_valid = 1'b0;
    dendrite_current  = '0;
    cfg_shift = 1'b0;
    cfg_din   = 1'b0;
    cfg_load  = 1'b0;
    do_reset();

    // Reset state.
    check("rst_membrane", 64'(membrane), 64'h0);
    check("rst_spike", 64'(output_spike), 64'h0);
    check("rst_refr", 64'(refractory), 64'h0);
    check("rst_count", 64'(spike_count), 64'h0);
    check("rst_dout", 64'(cfg_dout), 64'h0);

    // Defaults: 0x100 per cycle crosses 0x1000 on the 16th input.
    drive(1'b1, 12'h100);
    repeat (15) step();
    check("t1_mem15", 64'(membrane), 64'hF00);
    check("t1_nospike15", 64'(output_spike), 64'h0);
    step();
    drive(1'b0, 12'h000);
    check("t1_spike", 64'(output_spike), 64'h1);
    check("t1_mem_reset", 64'(membrane), 64'h0);
    check("t1_refr_on", 64'(refractory), 64'h1);
    check("t1_count", 64'(spike_count), 64'h1);
    for (int i = 0; i < 15; i++) begin
      step();
      check("t1_refr_hold", 64'(refractory), 64'h1);
      check("t1_spike_pulse", 64'(output_spike), 64'h0);
    end
    step();
    check("t1_refr_off", 64'(refractory), 64'h0);
    check("t1_mem_after", 64'(membrane), 64'h0);

    // Leak every cycle (tau_mem_scale = 0).
    do_reset();
    cfg_write({8'd0, 8'd16, 16'h1000, 16'h0000}, CFG_DEF);
    cfg_commit();
    drive(1'b1, 12'h7FF);
    step();
    check("t2_preset_a", 64'(membrane), 64'h7FF);
    drive(1'b1, 12'h080);
    step();
    check("t2_preset_b", 64'(membrane), 64'h800);
    drive(1'b0, 12'h000);
    step();
    check("t2_leak1", 64'(membrane), 64'h780);
    step();
    check("t2_leak2", 64'(membrane), 64'h708);

    // No refractory, low threshold: spike every cycle, counter saturates.
    do_reset();
    cfg_write({8'd16, 8'd0, 16'h0010, 16'h0000}, CFG_DEF);
    cfg_commit();
    drive(1'b1, 12'h010);
    step();
    check("t3_spike_first", 64'(output_spike), 64'h1);
    check("t3_count_first", 64'(spike_count), 64'h1);
    check("t3_no_refr", 64'(refractory), 64'h0);
    for (int i = 0; i < 253; i++) begin
      step();
      check("t3_spike_each", 64'(output_spike), 64'h1);
    end
    check("t3_count254", 64'(spike_count), 64'hFE);
    step();
    check("t3_count255", 64'(spike_count), 64'hFF);
    repeat (5) step();
    check("t3_count_sat", 64'(spike_count), 64'hFF);
    check("t3_spike_sat", 64'(output_spike), 64'h1);
    drive(1'b0, 12'h000);

    // Saturation at both rails.
    do_reset();
    cfg_write({8'd255, 8'd16, 16'h7FFF, 16'h0000}, CFG_DEF);
    cfg_commit();
    drive(1'b1, 12'h800);
    repeat (16) step();
    check("t4_min_reach", 64'(membrane), 64'h8000);
    repeat (4) step();
    check("t4_min_clamp", 64'(membrane), 64'h8000);
    check("t4_min_nospike", 64'(output_spike), 64'h0);
    drive(1'b1, 12'h7FF);
    repeat (32) step();
    check("t4_near_max", 64'(membrane), 64'h7FE0);
    check("t4_near_nospike", 64'(output_spike), 64'h0);
    step();
    check("t4_max_spike", 64'(output_spike), 64'h1);
    check("t4_max_mem", 64'(membrane), 64'h0);
    drive(1'b0, 12'h000);

    // Config chain replay, no-load isolation, load during refractory.
    do_reset();
    cfg_write({8'd16, 8'd4, 16'h0200, 16'h0040}, CFG_DEF);
    drive(1'b1, 12'h100);
    step();
    step();
    drive(1'b0, 12'h000);
    check("t5_noload_mem", 64'(membrane), 64'h200);
    check("t5_noload_spike", 64'(output_spike), 64'h0);
    check("t5_noload_refr", 64'(refractory), 64'h0);
    // Default leak ticks during this shift: 0x200 -> 0x1E0 -> 0x1C2 -> 0x1A6.
    cfg_write({8'd255, 8'd4, 16'h0300, 16'h0000}, {8'd16, 8'd4, 16'h0200, 16'h0040});
    cfg_commit();
    check("t5_leak_mem", 64'(membrane), 64'h1A6);
    cfg_write({8'd255, 8'd8, 16'h0180, 16'h0000}, {8'd255, 8'd4, 16'h0300, 16'h0000});
    check("t5_mem_hold", 64'(membrane), 64'h1A6);
    drive(1'b1, 12'h100);
    step();
    check("t5_mem_2a6", 64'(membrane), 64'h2A6);
    check("t5_below_thr", 64'(output_spike), 64'h0);
    step();
    check("t5_spike", 64'(output_spike), 64'h1);
    check("t5_refr1", 64'(refractory), 64'h1);
    cfg_commit();
    check("t5_refr2", 64'(refractory), 64'h1);
    check("t5_refr_mem", 64'(membrane), 64'h0);
    step();
    check("t5_refr3", 64'(refractory), 64'h1);
    step();
    check("t5_refr4", 64'(refractory), 64'h1);
    step();
    check("t5_refr_end", 64'(refractory), 64'h0);
    check("t5_refr_end_mem", 64'(membrane), 64'h0);
    step();
    check("t5_new_a", 64'(membrane), 64'h100);
    check("t5_new_a_spike", 64'(output_spike), 64'h0);
    step();
    check("t5_new_thr_spike", 64'(output_spike), 64'h1);
    check("t5_count2", 64'(spike_count), 64'h2);
    drive(1'b0, 12'h000);

    // Asynchronous reset mid-refractory.
    do_reset();
    cfg_write({8'd255, 8'd3, 16'h0010, 16'h0005}, CFG_DEF);
    cfg_commit();
    drive(1'b1, 12'h010);
    repeat (18) step();
    check("t6_pre_count", 64'(spike_count), 64'h5);
    check("t6_pre_refr", 64'(refractory), 64'h1);
    check("t6_pre_mem", 64'(membrane), 64'h5);
    check("t6_pre_dout", 64'(cfg_dout), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_mem", 64'(membrane), 64'h0);
    check("t6_async_refr", 64'(refractory), 64'h0);
    check("t6_async_count", 64'(spike_count), 64'h0);
    check("t6_async_spike", 64'(output_spike), 64'h0);
    check("t6_async_dout", 64'(cfg_dout), 64'h0);
    reset = 1'b0;
    step();
    check("t6_def_mem", 64'(membrane), 64'h10);
    check("t6_def_nospike", 64'(output_spike), 64'h0);
    drive(1'b0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lif_neuron_core.md
Name: lif_neuron_core

Overview:
- Parametrised leaky integrate-and-fire neuron, successor to the fixed-constant neuron block.
- Adds:
  - signed, saturating membrane arithmetic;
  - a true refractory state;
  - runtime-programmable leak period, refractory period, threshold and reset potential through a single-clock serial config chain;
  - a saturating spike counter.
- Sits behind the dendrite/synapse stage: consumes a per-cycle dendrite current and emits one-cycle spike pulses.
- Config chain daisy-chains across neurons.

Parameters:
- CURRENT_WIDTH, 12, signed dendrite current width (must be <= MEMBRANE_WIDTH).
- COUNTER_WIDTH, 8, width of leak/refractory period fields and of spike_count.
- MEMBRANE_WIDTH, 16, signed membrane potential width.
- LEAK_SHIFT, 4, leak per tick = membrane >>> LEAK_SHIFT (arithmetic).
- DEF_TAU_MEM, 16, reset value of tau_mem_scale.
- DEF_TAU_REF, 16, reset value of tau_ref_scale.
- DEF_V_THRESH, 16'h1000, reset value of v_thresh.
- DEF_V_RESET, 16'h0000, reset value of v_reset.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- input_spike_valid  in  1  dendrite_current valid this cycle.
- dendrite_current  in  CURRENT_WIDTH  signed current, sign-extended before use.
- cfg_shift  in  1  shift config chain one bit.
- cfg_din  in  1  serial config in.
- cfg_dout  out  1  serial config out = MSB of shadow register.
- cfg_load  in  1  copy shadow register to active config.
- output_spike  out  1  one-cycle spike pulse.
- refractory  out  1  high while in REFRACT state.
- membrane  out  MEMBRANE_WIDTH  current signed potential.
- spike_count  out  COUNTER_WIDTH  saturating spike count; cleared only by reset.

Behaviour:
- Config word, CFG_W = 2*COUNTER_WIDTH + 2*MEMBRANE_WIDTH bits, MSB to LSB: {tau_mem_scale, tau_ref_scale, v_thresh, v_reset}.
- Shadow register:
  - on cfg_shift, shadow <= {shadow[CFG_W-2:0], cfg_din};
  - reset value is the DEF_* concatenation.
- Active register:
  - on cfg_load, active <= shadow;
  - reset value is the DEF_* concatenation.
  - cfg_shift and cfg_load in the same cycle: load takes the pre-shift shadow.
- Leak counter:
  - counts 0..tau_mem_scale;
  - leak_tick is high in the cycle counter == tau_mem_scale, and the counter returns to 0 next cycle, giving period tau_mem_scale+1 (scale 0 = tick every cycle);
  - runs in all states;
  - cleared to 0 on cfg_load.
- Reset (async): membrane = active v_reset (DEF_V_RESET), output_spike = 0, refractory = 0, spike_count = 0, both counters = 0, state = INTEGRATE.
- State INTEGRATE, per cycle:
  - leak = leak_tick ? (membrane >>> LEAK_SHIFT) : 0;
  - inc = input_spike_valid ? sext(dendrite_current) : 0;
  - v_next = sat(membrane - leak + inc), computed at MEMBRANE_WIDTH+2 bits and clamped to the signed MEMBRANE_WIDTH range.
  - If v_next >= v_thresh (signed compare):
    - membrane <= v_reset, output_spike <= 1, spike_count <= min(count+1, max);
    - ref_cnt <= tau_ref_scale;
    - state <= REFRACT if tau_ref_scale != 0, else stay INTEGRATE.
  - Otherwise membrane <= v_next, output_spike <= 0.
- State REFRACT:
  - refractory = 1, membrane held at v_reset, inputs and leak ignored, output_spike = 0;
  - ref_cnt decrements each cycle; the cycle ref_cnt == 1, state <= INTEGRATE;
  - exactly tau_ref_scale refractory cycles after the spike cycle.
- Latency: input sampled in cycle N; membrane/output_spike update visible in cycle N+1. Back-to-back spikes are possible only with tau_ref_scale = 0.
- cfg_load during REFRACT: the running ref_cnt is unaffected; the new tau_ref_scale/v_thresh/v_reset apply from the next spike/compare. v_reset is not re-applied to the held membrane.
- Saturation: membrane never wraps; +max + positive current stays +max; -min - leak stays -min.
- refractory output is a registered state decode, reset 0.

Test Plan:
- Defaults, reset, constant current 0x100 each cycle, no leak ticks before crossing → output_spike pulse in the cycle after membrane would reach 0x1000 (16th input), membrane = 0, refractory high for 16 cycles, spike_count = 1.
- Load tau_mem_scale = 0, membrane preset to 0x0800 via inputs, then no input → each cycle membrane -= membrane>>>4: 0x0800 → 0x0780 → 0x0708.
- Load tau_ref_scale = 0, v_thresh = 0x0010, current 0x0010 every cycle → output_spike high every cycle, spike_count saturates at 0xFF and holds.
- Current -0x800 repeatedly with v_reset = 0 → membrane clamps at 0x8000 and never wraps positive; v_thresh = 0x7FFF with +0x7FF inputs → clamps at 0x7FFF and spikes (>=).
- Shift 48 bits with cfg_shift → cfg_dout replays the prior shadow contents MSB-first; without cfg_load, behaviour is unchanged; cfg_load mid-REFRACT → refractory length unchanged, next spike uses the new threshold.
- Assert reset asynchronously mid-REFRACT with spike_count = 5 → all outputs return to reset values immediately, without a clk edge; config reverts to DEF_*.
